// File: rtl/axil_memtest_pkg.sv
// Shared types and constants for the AXI-Lite memory tester.
package axil_memtest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADDR  = 2'b00,
        MODE_NADDR = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_WALK1 = 2'b11
    } mode_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    // Right-shifting Galois LFSR: the shifted-out bit folds the tap mask back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-Lite bundle with initiator and responder views.
interface taxi_axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport mst (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slv (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/memtest_pattern_gen.sv
// Test pattern source shared by the write and read passes; the LFSR register
// always holds the value belonging to the next word that will consume it.
module memtest_pattern_gen
    import axil_memtest_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
    parameter int                    IDX_WIDTH  = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  mode_t                mode,
    input  logic [31:0]          seed,
    input  logic                 load,
    input  logic                 step,
    input  logic [IDX_WIDTH-1:0] index,
    output logic [31:0]          data
);

    logic [31:0]           lfsr_q;
    logic [31:0]           seed_nz;
    logic [31:0]           lfsr_cur;
    logic [ADDR_WIDTH-1:0] addr;
    logic [4:0]            bit_pos;

    always_comb begin
        seed_nz  = (seed == 32'h0) ? 32'd1 : seed;
        // On load the word-0 value is needed in the same cycle as the reload.
        lfsr_cur = load ? lfsr_step(seed_nz) : lfsr_q;
        addr     = BASE_ADDR + (ADDR_WIDTH'(index) << 2);
        bit_pos  = 5'(index);
        data     = 32'h0;
        case (mode)
            MODE_ADDR:  data = 32'(addr);
            MODE_NADDR: data = ~32'(addr);
            MODE_LFSR:  data = lfsr_cur;
            MODE_WALK1: data = 32'd1 << bit_pos;
            default:    data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 32'd1;
        end else if (load) begin
            lfsr_q <= lfsr_step(seed_nz);
        end else if (step) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

endmodule

// File: rtl/axil_memtest.sv
// AXI-Lite memory tester: write pass then read-and-compare pass over
// NUM_WORDS words, one transaction outstanding at a time.
module axil_memtest
    import axil_memtest_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
    parameter int                    NUM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    taxi_axil_if.mst              m_axil
);

    localparam int IDX_WIDTH = $clog2(NUM_WORDS + 1);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("axil_memtest supports DATA_WIDTH = 32 only");
    end

    state_t                state;
    mode_t                 mode_q;
    logic [31:0]           seed_q;
    logic [IDX_WIDTH-1:0]  word_idx;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [31:0]           wdata_q;

    logic                  is_idle, start_acc, last;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, w_ok;
    logic                  b_err, r_err, err_hit;
    logic [15:0]           err_nxt;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic                  gen_load, gen_step;
    logic [IDX_WIDTH-1:0]  gen_index;
    mode_t                 gen_mode;
    logic [31:0]           gen_seed, gen_data;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_WIDTH-1:0] idx);
        return BASE_ADDR + (ADDR_WIDTH'(idx) << 2);
    endfunction

    // Valid/ready: a beat transfers on the rising edge where both are high;
    // valids are registered, never retracted before their handshake, and keep
    // address/data stable; each ready is high only in its response state.
    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = 4'hF;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

    always_comb begin
        is_idle   = (state == IDLE) || (state == FIN);
        start_acc = is_idle && start;
        last      = (word_idx == IDX_WIDTH'(NUM_WORDS - 1));
        aw_hs     = awvalid_q && m_axil.awready;
        w_hs      = wvalid_q && m_axil.wready;
        aw_ok     = !awvalid_q || m_axil.awready;
        w_ok      = !wvalid_q || m_axil.wready;
        b_hs      = bready_q && m_axil.bvalid;
        ar_hs     = arvalid_q && m_axil.arready;
        r_hs      = rready_q && m_axil.rvalid;
        b_err     = b_hs && (m_axil.bresp != RESP_OKAY);
        r_err     = r_hs && ((m_axil.rresp != RESP_OKAY) || (m_axil.rdata != gen_data));
        err_hit   = b_err || r_err;
        err_nxt   = (err_hit && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
        err_addr  = b_err ? awaddr_q : araddr_q;

        // Write pass looks one word ahead; read pass checks the current word.
        gen_load  = start_acc || ((state == WR_RESP) && b_hs && last);
        gen_step  = ((state == WR_REQ) && w_hs) || ((state == RD_RESP) && r_hs);
        gen_index = (state == RD_RESP) ? word_idx : (is_idle ? '0 : word_idx + 1'b1);
        gen_mode  = is_idle ? mode_t'(mode) : mode_q;
        gen_seed  = is_idle ? seed : seed_q;
    end

    memtest_pattern_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_pattern_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (gen_mode),
        .seed  (gen_seed),
        .load  (gen_load),
        .step  (gen_step),
        .index (gen_index),
        .data  (gen_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mode_q         <= MODE_ADDR;
            seed_q         <= 32'h0;
            word_idx       <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            awaddr_q       <= '0;
            araddr_q       <= '0;
            wdata_q        <= 32'h0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'h0;
            first_err_addr <= '0;
        end else begin
            err_count <= err_nxt;
            if (err_hit && (err_count == 16'h0)) begin
                first_err_addr <= err_addr;
            end

            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        mode_q         <= mode_t'(mode);
                        seed_q         <= seed;
                        word_idx       <= '0;
                        awaddr_q       <= BASE_ADDR;
                        wdata_q        <= gen_data;
                        awvalid_q      <= 1'b1;
                        wvalid_q       <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 16'h0;
                        first_err_addr <= '0;
                        state          <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs) wvalid_q <= 1'b0;
                    if (aw_ok && w_ok) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        if (last) begin
                            word_idx  <= '0;
                            araddr_q  <= BASE_ADDR;
                            arvalid_q <= 1'b1;
                            state     <= RD_REQ;
                        end else begin
                            word_idx  <= word_idx + 1'b1;
                            awaddr_q  <= word_addr(word_idx + 1'b1);
                            wdata_q   <= gen_data;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_hs) begin
                        rready_q <= 1'b0;
                        if (last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == 16'h0);
                            state <= FIN;
                        end else begin
                            word_idx  <= word_idx + 1'b1;
                            araddr_q  <= word_addr(word_idx + 1'b1);
                            arvalid_q <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_memtest.sv
// Directed bench for axil_memtest against a small AXI-Lite memory model with
// fault-injection knobs.
`timescale 1ns/1ps
module tb_axil_memtest;
    import axil_memtest_pkg::*;

    localparam int          NW   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [31:0] seed = 32'h0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) axil ();

    axil_memtest #(.NUM_WORDS(NW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .m_axil         (axil)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    int aw_delay = 0, w_delay = 0, r_delay = 0;
    int corrupt_idx = -1, berr_idx = -1, rerr_idx = -1;

    logic [31:0] mem [NW];
    logic        got_aw, got_w, pend_r;
    logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
    int          aw_wait, w_wait, r_wait;
    int          widx, ridx;

    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] exp_q[$];
    int          b_count;
    logic        split_seen;
    int          aw_unstable;
    logic        prev_aw_wait;
    logic [31:0] prev_awaddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axil.awready <= 1'b0;
            axil.wready  <= 1'b0;
            axil.bvalid  <= 1'b0;
            axil.bresp   <= 2'b00;
            axil.arready <= 1'b0;
            axil.rvalid  <= 1'b0;
            axil.rresp   <= 2'b00;
            axil.rdata   <= 32'h0;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
            pend_r <= 1'b0;
            aw_wait <= 0;
            w_wait  <= 0;
            r_wait  <= 0;
        end else begin
            if (axil.awvalid && axil.awready) begin
                axil.awready <= 1'b0;
                got_aw <= 1'b1;
                aw_addr_q <= axil.awaddr;
                aw_wait <= 0;
            end else if (axil.awvalid && !got_aw) begin
                if (aw_wait >= aw_delay) axil.awready <= 1'b1;
                else aw_wait <= aw_wait + 1;
            end
            if (axil.wvalid && axil.wready) begin
                axil.wready <= 1'b0;
                got_w <= 1'b1;
                w_data_q <= axil.wdata;
                w_wait <= 0;
            end else if (axil.wvalid && !got_w) begin
                if (w_wait >= w_delay) axil.wready <= 1'b1;
                else w_wait <= w_wait + 1;
            end
            if (axil.bvalid && axil.bready) begin
                axil.bvalid <= 1'b0;
                got_aw <= 1'b0;
                got_w <= 1'b0;
                b_count = b_count + 1;
            end else if (got_aw && got_w && !axil.bvalid) begin
                widx = int'((aw_addr_q - BASE) >> 2);
                axil.bvalid <= 1'b1;
                axil.bresp  <= (widx == berr_idx) ? 2'b10 : 2'b00;
                mem[widx % NW] <= w_data_q;
                wr_addr_log.push_back(aw_addr_q);
                wr_data_log.push_back(w_data_q);
            end
            if (axil.arvalid && axil.arready) begin
                axil.arready <= 1'b0;
                ar_addr_q <= axil.araddr;
                pend_r <= 1'b1;
                r_wait <= 0;
            end else if (axil.arvalid && !pend_r) begin
                axil.arready <= 1'b1;
            end
            if (axil.rvalid && axil.rready) begin
                axil.rvalid <= 1'b0;
                pend_r <= 1'b0;
            end else if (pend_r && !axil.rvalid) begin
                if (r_wait >= r_delay) begin
                    ridx = int'((ar_addr_q - BASE) >> 2);
                    axil.rdata  <= mem[ridx % NW] ^ ((ridx == corrupt_idx) ? 32'd1 : 32'd0);
                    axil.rresp  <= (ridx == rerr_idx) ? 2'b10 : 2'b00;
                    axil.rvalid <= 1'b1;
                end else begin
                    r_wait <= r_wait + 1;
                end
            end
        end
    end

    // Protocol observations: W finishing ahead of AW, and AW address stability.
    always @(posedge clk) begin
        if (rst_n) begin
            if (axil.awvalid && !axil.wvalid) split_seen = 1'b1;
            if (prev_aw_wait && (axil.awaddr != prev_awaddr)) aw_unstable = aw_unstable + 1;
            prev_aw_wait = axil.awvalid && !axil.awready;
            prev_awaddr  = axil.awaddr;
        end else begin
            prev_aw_wait = 1'b0;
        end
    end

    // ---------------- scoreboard / driver tasks ----------------
    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        exp_q.delete();
        b_count = 0;
        split_seen = 1'b0;
        aw_unstable = 0;
    endtask

    task automatic start_test(input logic [1:0] m, input logic [31:0] s);
        @(negedge clk);
        mode = m;
        seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~m;
        seed = 32'hDEAD_BEEF;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared", 32'(done), 32'd0);
        check("pass_cleared", 32'(pass), 32'd0);
        check("err_cleared", 32'(err_count), 32'd0);
        check("first_err_cleared", first_err_addr, 32'h0);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wr_data_log.size()), 32'(NW));
        check({tag, "_b_count"}, 32'(b_count), 32'(NW));
        for (int i = 0; i < NW; i++) begin
            check({tag, "_wr_addr"}, (i < wr_addr_log.size()) ? wr_addr_log[i] : 32'hxxxx_xxxx,
                  BASE + 32'(4 * i));
            check({tag, "_wr_data"}, (i < wr_data_log.size()) ? wr_data_log[i] : 32'hxxxx_xxxx,
                  exp_q.pop_front());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_first"}, first_err_addr, 32'h0);
        check({tag, "_valids"}, {29'h0, axil.awvalid, axil.wvalid, axil.arvalid}, 32'h0);
        check({tag, "_readies"}, {30'h0, axil.bready, axil.rready}, 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_logs();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // V1: address pattern, ideal memory
        clear_logs();
        exp_q = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_000C};
        start_test(2'b00, 32'h0);
        wait_done();
        check("v1_pass", 32'(pass), 32'd1);
        check("v1_err", 32'(err_count), 32'd0);
        check("v1_no_split", 32'(split_seen), 32'd0);
        check_writes("v1");

        // V2: LFSR from seed 0 (replaced by 1)
        clear_logs();
        exp_q = '{32'h8020_0003, 32'hC030_0002, 32'h6018_0001, 32'hB02C_0003};
        start_test(2'b10, 32'h0);
        wait_done();
        check("v2_pass", 32'(pass), 32'd1);
        check("v2_err", 32'(err_count), 32'd0);
        check_writes("v2");

        // V3: word 2 read back with bit 0 flipped
        clear_logs();
        corrupt_idx = 2;
        exp_q = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_000C};
        start_test(2'b00, 32'h0);
        wait_done();
        check("v3_err", 32'(err_count), 32'd1);
        check("v3_first", first_err_addr, 32'h4000_0008);
        check("v3_pass", 32'(pass), 32'd0);
        check("v3_done", 32'(done), 32'd1);
        check_writes("v3");

        // V4: SLVERR on write 0 and read 3, inverted-address pattern
        clear_logs();
        corrupt_idx = -1;
        berr_idx = 0;
        rerr_idx = 3;
        exp_q = '{32'hBFFF_FFFF, 32'hBFFF_FFFB, 32'hBFFF_FFF7, 32'hBFFF_FFF3};
        start_test(2'b01, 32'h0);
        wait_done();
        check("v4_err", 32'(err_count), 32'd2);
        check("v4_first", first_err_addr, 32'h4000_0000);
        check("v4_pass", 32'(pass), 32'd0);
        check_writes("v4");

        // V5: awready 3 cycles late, wready immediate, walking one
        clear_logs();
        berr_idx = -1;
        rerr_idx = -1;
        aw_delay = 3;
        exp_q = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_0008};
        start_test(2'b11, 32'h0);
        wait_done();
        check("v5_split_seen", 32'(split_seen), 32'd1);
        check("v5_aw_stable", 32'(aw_unstable), 32'd0);
        check("v5_pass", 32'(pass), 32'd1);
        check_writes("v5");

        // V6: reset while waiting in RD_RESP, then a clean run
        clear_logs();
        aw_delay = 0;
        r_delay = 6;
        start_test(2'b00, 32'h0);
        begin
            int cyc = 0;
            while (!axil.rready && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("v6_rready_seen", 32'(axil.rready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("v6_reset");
        repeat (2) @(negedge clk);
        check_idle_outputs("v6_reset_held");
        rst_n = 1'b1;
        r_delay = 0;
        clear_logs();
        exp_q = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_000C};
        start_test(2'b00, 32'h0);
        wait_done();
        check("v6_pass", 32'(pass), 32'd1);
        check("v6_err", 32'(err_count), 32'd0);
        check_writes("v6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axil_memtest.md
AXIL_MEMTEST -- requirements
Module: axil_memtest

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32: AXI-Lite data width; only 32 is supported.
REQ-003 Parameter BASE_ADDR, default 32'h4000_0000: byte address of the first word tested.
REQ-004 Parameter NUM_WORDS, default 1024: words per pass; range 1..2^24.
REQ-005 Port list, one per line:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: start a test.
- mode, input, 2: pattern select.
- seed, input, 32: LFSR seed.
- busy, output, 1: test in progress.
- done, output, 1: test finished.
- pass, output, 1: test passed.
- err_count, output, 16: error count.
- first_err_addr, output, ADDR_WIDTH: address of the first error.
- m_axil, taxi_axil_if master modport: AXI-Lite initiator toward axil_sdram.

Function
REQ-006 The block SHALL act as the AXI-Lite initiator for the axil_sdram responder: first a write pass over NUM_WORDS, then a read-and-compare pass.
REQ-007 The FSM SHALL use states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN.
- IDLE->WR_REQ on start.
- WR_REQ->WR_RESP when both AW and W have handshaken.
- WR_RESP->WR_REQ on the B handshake, or ->RD_REQ after the last word.
- RD_REQ->RD_RESP on the AR handshake.
- RD_RESP->RD_REQ on the R handshake, or ->FIN after the last word.
- FIN->WR_REQ on start; otherwise FIN holds.
REQ-008 Word i SHALL use address BASE_ADDR + 4*i, awprot = arprot = 3'b000, and wstrb = 4'hF.
REQ-009 On entering WR_REQ, awvalid and wvalid SHALL assert together; each SHALL drop independently the cycle after its own handshake.
- The address and data SHALL stay stable while valid is high.
REQ-010 Only one transaction SHALL be outstanding at a time; bready SHALL be high only in WR_RESP and rready only in RD_RESP.
REQ-011 Data for word i SHALL follow mode:
- 00: the word's address.
- 01: the bitwise NOT of the address.
- 10: a 32-bit Galois LFSR (taps 0x80200003) stepped once per word; seed 0 is replaced by 1.
- 11: walking one, 1 << (i mod 32).
REQ-012 The read pass SHALL regenerate the identical sequence (the LFSR is reloaded from the seed latched at start) and compare rdata against the expected word.
REQ-013 An error SHALL be counted on any of: rdata mismatch, rresp != OKAY, or bresp != OKAY.
- err_count SHALL saturate at 16'hFFFF.
- first_err_addr SHALL capture the address of the first error only.
REQ-014 mode and seed SHALL be latched on start in IDLE or FIN; start SHALL be ignored while busy.
REQ-015 busy SHALL be high from the cycle after start until FIN is entered.
REQ-016 done SHALL be high in FIN, and pass SHALL equal done AND (err_count == 0).
REQ-017 Restarting from FIN SHALL clear done, pass, err_count and first_err_addr in the cycle after start.
REQ-018 The word counter SHALL be wide enough for NUM_WORDS with no wrap; the address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-019 The block SHALL NOT time out; a responder that never answers holds the FSM in its current state.

Reset
REQ-020 On rst_n low, asynchronously, the state SHALL go to IDLE and all valid/ready outputs, busy, done, pass, err_count and first_err_addr SHALL go to 0.
REQ-021 A reset mid-transaction SHALL abandon that transaction without completing it; the responder's own reset is relied upon to stay consistent.
REQ-022 All AXI outputs SHALL be registered, with no combinational path from input to output.

Structure
REQ-023 The package axil_memtest_pkg SHALL hold the state enum, the mode enum, the LFSR polynomial constant and the OKAY resp constant.
REQ-024 The pattern generator SHALL be a sub-module, memtest_pattern_gen, with inputs mode, seed, load, step and index, and output data; one instance SHALL serve both passes.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- V1: mode=00, NUM_WORDS=4, ideal memory model -> writes 0x40000000..0x4000000C with data equal to the address; done=1, pass=1, err_count=0.
- V2: mode=10, seed=0 -> first written word equals the LFSR step from 1; the read pass matches; pass=1.
- V3: model corrupts word 2 on readback (bit 0 flipped) -> err_count=1, first_err_addr=0x40000008, pass=0.
- V4: model returns bresp=SLVERR on word 0 and rresp=SLVERR on word 3 -> err_count=2, first_err_addr=0x40000000.
- V5: responder delays awready by 3 cycles and wready by 0 cycles -> wvalid drops after its handshake while awvalid is held; exactly one B per word; data is correct.
- V6: rst_n asserted during RD_RESP, then start -> all outputs 0 during reset; the new test completes with pass=1.
